pin_bus_sequencer: RTL

//  Host-side master for the UP1024 pin-access bus (D, nD_A, nWR, nRD) shared by FPGA0/FPGA1.

---
 rtl/pin_bus_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pin_bus_sequencer.sv
// Host-side master for the UP1024 pin-access bus: one command becomes an optional address cycle plus a data/read cycle.
// Skips the address cycle on a cache hit; one command in flight, cmd_ready only in IDLE, no response backpressure.
module pin_bus_sequencer #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1,
  parameter int T_GAP    = 1
) (
  input  logic       IFCLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_fpga,
  input  logic [3:0] cmd_bank,
  input  logic [7:0] cmd_data,
  input  logic       flush,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] BUS_DO,
  output logic       BUS_OE,
  input  logic [7:0] BUS_DI,
  output logic       BUS_nD_A,
  output logic       BUS_nWR,
  output logic       BUS_nRD
);

  localparam int CW = 8;

  localparam logic [1:0] OP_WR_OUT = 2'b00;
  localparam logic [1:0] OP_WR_OE  = 2'b01;
  localparam logic [1:0] OP_RD     = 2'b10;
  localparam logic [1:0] OP_ADDR   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET, S_A_STB, S_A_HLD,
    S_W_SET, S_W_STB, S_W_HLD,
    S_R_SET, S_R_STB, S_R_HLD,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   phase_len;
  logic            phase_done;

  logic [1:0]      op_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [7:0]      cache_addr;
  logic            cache_vld;

  logic [7:0]      addr_in;
  logic            hit_in;
  logic            accept;

  assign addr_in = {cmd_op == OP_WR_OE, 2'b00, cmd_fpga, cmd_bank};
  assign hit_in  = cache_vld && (addr_in == cache_addr) && (cmd_op != OP_ADDR);
  assign accept  = (state == S_IDLE) && cmd_valid && !RST;

  always_comb begin
    phase_len = CW'(1);
    case (state)
      S_A_SET, S_W_SET, S_R_SET: phase_len = CW'(T_SETUP);
      S_A_STB, S_W_STB, S_R_STB: phase_len = CW'(T_STROBE);
      S_A_HLD, S_W_HLD, S_R_HLD: phase_len = CW'(T_HOLD);
      S_GAP:                     phase_len = CW'(T_GAP);
      default:                   phase_len = CW'(1);
    endcase
  end

  assign phase_done = (cnt == phase_len - CW'(1));

  always_ff @(posedge IFCLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= phase_done ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    BUS_OE    = 1'b0;
    BUS_DO    = 8'h00;
    BUS_nD_A  = 1'b1;
    BUS_nWR   = 1'b1;
    BUS_nRD   = 1'b1;
    case (state)
      S_IDLE: begin
        cmd_ready = !RST;
        if (cmd_valid && !RST) begin
          if (!hit_in)                state_nxt = S_A_SET;
          else if (cmd_op == OP_RD)   state_nxt = S_R_SET;
          else                        state_nxt = S_W_SET;
        end
      end
      S_A_SET, S_A_STB, S_A_HLD: begin
        BUS_OE  = 1'b1;
        BUS_DO  = addr_q;
        BUS_nWR = (state != S_A_STB);
        if (phase_done) begin
          case (state)
            S_A_SET: state_nxt = S_A_STB;
            S_A_STB: state_nxt = S_A_HLD;
            default: begin
              if (op_q == OP_ADDR)    state_nxt = S_GAP;
              else if (op_q == OP_RD) state_nxt = S_R_SET;
              else                    state_nxt = S_W_SET;
            end
          endcase
        end
      end
      S_W_SET, S_W_STB, S_W_HLD: begin
        BUS_OE   = 1'b1;
        BUS_DO   = data_q;
        BUS_nD_A = 1'b0;
        BUS_nWR  = (state != S_W_STB);
        if (phase_done) begin
          case (state)
            S_W_SET: state_nxt = S_W_STB;
            S_W_STB: state_nxt = S_W_HLD;
            default: state_nxt = S_GAP;
          endcase
        end
      end
      S_R_SET, S_R_STB, S_R_HLD: begin
        BUS_nD_A = 1'b0;
        BUS_nRD  = (state != S_R_STB);
        if (phase_done) begin
          case (state)
            S_R_SET: state_nxt = S_R_STB;
            S_R_STB: state_nxt = S_R_HLD;
            default: state_nxt = S_GAP;
          endcase
        end
      end
      S_GAP: begin
        if (phase_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge IFCLK) begin
    if (RST) begin
      op_q       <= OP_WR_OUT;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      cache_addr <= 8'h00;
      cache_vld  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
    end else begin
      rsp_valid <= (state == S_R_HLD) && phase_done;
      if (accept) begin
        op_q   <= cmd_op;
        addr_q <= addr_in;
        data_q <= cmd_data;
      end
      if ((state == S_R_STB) && phase_done) rsp_data <= BUS_DI;
      if ((state == S_A_HLD) && phase_done) begin
        cache_addr <= addr_q;
        cache_vld  <= 1'b1;
      end
      // A flush landing on the same edge as the cache fill must leave it invalid.
      if (flush) cache_vld <= 1'b0;
    end
  end

endmodule
